cpu_ad48_alu_unit: RTL and testbench
====================================

# cpu_ad48_alu_unit

Parametrised, handshaked execution unit generalising the single-cycle ALU of the cpu_ad48 core to any data width. It adds a result/flag register stage, valid/ready flow control, a destination tag passthrough and an optional iterative multiplier. It sits between decode/register-read and writeback in the next-generation pipeline.

## Interface
- WIDTH, 48: data width in bits (≥ 8).
- TAG_W, 4: width of the opaque destination tag carried with each operation.
- SHW, $clog2(WIDTH): shift-amount field width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts an operation this cycle.
- in_func  in  4  function code (package constants).
- in_a  in  WIDTH  operand A (shift source, NOT source).
- in_b  in  WIDTH  operand B (shift amount from in_b[SHW:0]).
- in_tag  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- out_res  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  4  {V, C, N, Z}.
- out_err  out  1  illegal function code.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !busy && (!out_valid || out_ready). One op in flight; full throughput for single-cycle ops while out_ready is high.
- Function codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, NOT 8, MUL 9. Codes 10–15 are illegal.
- ADD/SUB: WIDTH-bit wraparound. C = carry-out for ADD and borrow for SUB. V = signed overflow. V and C are 0 for all other functions.
- Shifts: the amount is in_b[SHW:0]. If amount ≥ WIDTH, SLL/SRL give 0 and SRA gives all sign bits. in_b bits above SHW are ignored.
- NOT: result = ~in_a; in_b is ignored.
- N = result[WIDTH-1]; Z = (result == 0). Both apply to every function, MUL included.
- Illegal code: result 0, flags 0 except Z = 1, out_err = 1, single-cycle.
- States:
  - IDLE: accepting operations.
  - MUL: busy; a radix-2 shift-add loop runs for WIDTH iterations.
  - Return to IDLE loads the output register.
- MUL returns the low WIDTH bits of the unsigned product (equal to the low bits of the signed product).
- The output register holds out_res, out_tag, out_flags and out_err stable while out_valid && !out_ready.

## Timing
- Reset: out_valid = 0, out_res = 0, out_tag = 0, out_flags = 0, out_err = 0, state IDLE, in_ready = 1 from the first cycle after reset deasserts.
- Single-cycle ops: accepted at edge N, out_valid high after edge N+1 (latency 1).
- MUL: accepted at edge N, out_valid high after edge N+WIDTH+1. in_ready is 0 throughout.
- Simultaneous out transfer and new in transfer in the same cycle: the register is replaced; out_valid stays 1.
- rst during MUL or while holding a result: the op is discarded, reset values apply, and no result is emitted.
- in_* are sampled only on a transfer; they may change freely otherwise.

## Configuration
- CPU_AD48_ALU_MUL_EN defined: the multiplier is compiled in; MUL behaves as above.
- Undefined: no multiplier logic exists; MUL (code 9) is treated as illegal (single-cycle, result 0, out_err = 1).

## Structure
- Package cpu_ad48_alu_pkg holds:
  - function-code localparams F_ADD…F_MUL;
  - flag bit indices FLAG_Z 0, FLAG_N 1, FLAG_C 2, FLAG_V 3;
  - the state enum.
- Sub-module cpu_ad48_mul_seq (start/done, WIDTH-parametrised shift-add core) is instantiated only under CPU_AD48_ALU_MUL_EN.

## Test plan
- ADD 5 + 7, tag 3 -> next cycle: res 12, tag 3, flags Z = 0, N = 0, C = 0, V = 0. SUB 5 − 7 -> res 0xFFFFFFFFFFFE, N = 1, C = 1.
- SRA 0xFFFFFFFFFFF9 (−7) by 1 -> 0xFFFFFFFFFFFC; SLL 5 by 48 -> 0, Z = 1; SRA 0x800000000000 by 60 -> all ones.
- MUL 12345 × 678 (macro on) -> 8369910 exactly 49 cycles after accept, in_ready low for 48 cycles; macro off -> res 0, out_err = 1 after 1 cycle.
- Backpressure: out_ready low for 3 cycles after result -> out_res/tag/flags stable, in_ready 0; release with in_valid high -> new op accepted the same cycle, next result the following cycle.
- Back-to-back ADDs with out_ready held 1 -> one result per cycle, tags in order 0,1,2,3.
- rst asserted mid-MUL (cycle 20) -> out_valid never rises for that op; in_ready 1 the first cycle after rst deasserts; func code 12 -> out_err 1, Z = 1.

Source files
------------

// File: rtl/cpu_ad48_alu_pkg.sv
// Shared constants for the cpu_ad48 execution unit: function codes, flag bit
// positions and the sequencing state encoding.
package cpu_ad48_alu_pkg;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_SLL = 4'd5;
  localparam logic [3:0] F_SRL = 4'd6;
  localparam logic [3:0] F_SRA = 4'd7;
  localparam logic [3:0] F_NOT = 4'd8;
  localparam logic [3:0] F_MUL = 4'd9;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/cpu_ad48_alu_unit_mul_seq.sv
// Radix-2 shift-add multiplier core: WIDTH iterations after start, the last
// iteration is folded combinationally into product_c when done_c is high.
module cpu_ad48_mul_seq #(
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next  = mplier[0] ? acc + mcand : acc;
  assign done_c    = running && (cnt == LAST);
  assign product_c = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_ad48_alu_unit.sv
// Handshaked, registered ALU execution unit. Define CPU_AD48_ALU_MUL_EN to
// compile in the iterative multiplier; otherwise MUL is an illegal code.
module cpu_ad48_alu_unit
  import cpu_ad48_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned AMT_W = SHW + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  state_e state_q, state_d;
  logic   in_fire;
  logic   load;

  logic [SHW:0]     amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  logic [WIDTH-1:0] ld_res;
  logic [TAG_W-1:0] ld_tag;
  logic             ld_c, ld_v, ld_err;
  logic [3:0]       ld_flags;

  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign amt      = in_b[SHW:0];

`ifdef CPU_AD48_ALU_MUL_EN
  logic             mul_start;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_res_c;
  logic [TAG_W-1:0] pend_tag;

  cpu_ad48_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (in_a),
    .b         (in_b),
    .done_c    (mul_done_c),
    .product_c (mul_res_c)
  );

  always_ff @(posedge clk) begin
    if (rst)            pend_tag <= '0;
    else if (mul_start) pend_tag <= in_tag;
  end
`endif

  // Single-cycle datapath; any code not decoded here reports an error.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = '0;
    case (in_func)
      F_ADD: begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      F_SUB: begin
        sum     = {1'b0, in_a} - {1'b0, in_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_a[MSB] != in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      F_AND: alu_res = in_a & in_b;
      F_OR:  alu_res = in_a | in_b;
      F_XOR: alu_res = in_a ^ in_b;
      F_SLL: alu_res = (amt >= AMT_W'(WIDTH)) ? '0 : (in_a << amt);
      F_SRL: alu_res = (amt >= AMT_W'(WIDTH)) ? '0 : (in_a >> amt);
      F_SRA: alu_res = (amt >= AMT_W'(WIDTH)) ? {WIDTH{in_a[MSB]}}
                                              : WIDTH'($signed(in_a) >>> amt);
      F_NOT: alu_res = ~in_a;
      default: alu_err = 1'b1;
    endcase
  end

  // Sequencing: next state and selection of what the output register loads.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ld_res  = alu_res;
    ld_tag  = in_tag;
    ld_c    = alu_c;
    ld_v    = alu_v;
    ld_err  = alu_err;
`ifdef CPU_AD48_ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          load = 1'b1;
`ifdef CPU_AD48_ALU_MUL_EN
          if (in_func == F_MUL) begin
            load      = 1'b0;
            mul_start = 1'b1;
            state_d   = S_MUL;
          end
`endif
        end
      end
      S_MUL: begin
`ifdef CPU_AD48_ALU_MUL_EN
        if (mul_done_c) begin
          load    = 1'b1;
          ld_res  = mul_res_c;
          ld_tag  = pend_tag;
          ld_c    = 1'b0;
          ld_v    = 1'b0;
          ld_err  = 1'b0;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_flags         = '0;
    ld_flags[FLAG_Z] = (ld_res == '0);
    ld_flags[FLAG_N] = ld_res[MSB];
    ld_flags[FLAG_C] = ld_c;
    ld_flags[FLAG_V] = ld_v;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Output register: load wins over a simultaneous consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_res   <= ld_res;
      out_tag   <= ld_tag;
      out_flags <= ld_flags;
      out_err   <= ld_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ad48_alu_unit.sv
// Directed self-checking bench for cpu_ad48_alu_unit (WIDTH 48, TAG_W 4).
module tb_cpu_ad48_alu_unit;
  import cpu_ad48_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [47:0] in_a;
  logic [47:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_res;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_ad48_alu_unit #(.WIDTH(48), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_func   (in_func),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer an op and return #1 after the edge on which it was accepted.
  task automatic issue(input logic [3:0] f, input logic [47:0] a, input logic [47:0] b,
                       input logic [3:0] t);
    int n = 0;
    in_func = f; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [3:0] f, input logic [47:0] a,
                        input logic [47:0] b, input logic [3:0] t, input logic [47:0] er,
                        input logic [3:0] ef, input logic ee);
    issue(f, a, b, t);
    check_eq({nm, "_valid"}, out_valid, 1);
    check_eq({nm, "_res"},   out_res,   er);
    check_eq({nm, "_tag"},   out_tag,   t);
    check_eq({nm, "_flags"}, out_flags, ef);
    check_eq({nm, "_err"},   out_err,   ee);
  endtask

  initial begin
    int lat;
    int low;
    int rises;
    logic [47:0] exp_mul;
    logic [3:0]  exp_mflags;
    logic        exp_merr;
    int          exp_lat;
    int          exp_low;

    rst = 1'b1; in_valid = 1'b0; in_func = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_res",   out_res,   0);
    check_eq("rst_out_tag",   out_tag,   0);
    check_eq("rst_out_flags", out_flags, 0);
    check_eq("rst_out_err",   out_err,   0);
    check_eq("rst_in_ready",  in_ready,  1);

    // flags are {V,C,N,Z}
    run_op("add_5_7",   F_ADD, 48'd5, 48'd7, 4'd3, 48'd12, 4'b0000, 1'b0);
    run_op("sub_5_7",   F_SUB, 48'd5, 48'd7, 4'd1, 48'hFFFF_FFFF_FFFE, 4'b0110, 1'b0);
    run_op("sra_m7_1",  F_SRA, 48'hFFFF_FFFF_FFF9, 48'd1, 4'd2, 48'hFFFF_FFFF_FFFC, 4'b0010, 1'b0);
    run_op("sll_5_48",  F_SLL, 48'd5, 48'd48, 4'd4, 48'd0, 4'b0001, 1'b0);
    run_op("sra_min_60", F_SRA, 48'h8000_0000_0000, 48'd60, 4'd5, 48'hFFFF_FFFF_FFFF, 4'b0010, 1'b0);
    run_op("add_ovf",   F_ADD, 48'h7FFF_FFFF_FFFF, 48'd1, 4'd6, 48'h8000_0000_0000, 4'b1010, 1'b0);
    run_op("add_carry", F_ADD, 48'hFFFF_FFFF_FFFF, 48'd1, 4'd7, 48'd0, 4'b0101, 1'b0);
    run_op("sub_ovf",   F_SUB, 48'h8000_0000_0000, 48'd1, 4'd8, 48'h7FFF_FFFF_FFFF, 4'b1000, 1'b0);
    run_op("srl_47",    F_SRL, 48'h8000_0000_0000, 48'd47, 4'd9, 48'd1, 4'b0000, 1'b0);
    run_op("sll_hi_ign", F_SLL, 48'd1, 48'h12F, 4'd10, 48'h8000_0000_0000, 4'b0010, 1'b0);
    run_op("and",       F_AND, 48'hF0F0, 48'hFF00, 4'd11, 48'hF000, 4'b0000, 1'b0);
    run_op("or",        F_OR,  48'hF0F0, 48'h0F00, 4'd12, 48'hFFF0, 4'b0000, 1'b0);
    run_op("xor",       F_XOR, 48'hFFFF, 48'h0F0F, 4'd13, 48'hF0F0, 4'b0000, 1'b0);
    run_op("not",       F_NOT, 48'd0, 48'd123, 4'd14, 48'hFFFF_FFFF_FFFF, 4'b0010, 1'b0);

`ifdef CPU_AD48_ALU_MUL_EN
    exp_mul = 48'd8369910; exp_mflags = 4'b0000; exp_merr = 1'b0; exp_lat = 49; exp_low = 48;
`else
    exp_mul = 48'd0;       exp_mflags = 4'b0001; exp_merr = 1'b1; exp_lat = 1;  exp_low = 0;
`endif
    issue(F_MUL, 48'd12345, 48'd678, 4'd5);
    lat = 1; low = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    check_eq("mul_latency",  lat, exp_lat);
    check_eq("mul_busy_cyc", low, exp_low);
    check_eq("mul_res",      out_res, exp_mul);
    check_eq("mul_tag",      out_tag, 5);
    check_eq("mul_flags",    out_flags, exp_mflags);
    check_eq("mul_err",      out_err, exp_merr);

    // Backpressure: held result, ignored offer, then release with a new op.
    idle(1);
    out_ready = 1'b0;
    issue(F_ADD, 48'd100, 48'd23, 4'd7);
    check_eq("bp_first_res", out_res, 123);
    in_func = F_SUB; in_a = 48'd999; in_b = 48'd1; in_tag = 4'd9; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_res",   out_res, 123);
      check_eq("bp_hold_tag",   out_tag, 7);
      check_eq("bp_hold_flags", out_flags, 4'b0000);
      check_eq("bp_in_ready",   in_ready, 0);
    end
    in_func = F_XOR; in_a = 48'hFF; in_b = 48'h0F; in_tag = 4'd8; out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_next_valid", out_valid, 1);
    check_eq("bp_next_res",   out_res, 48'hF0);
    check_eq("bp_next_tag",   out_tag, 8);

    // Back-to-back single-cycle ops at full rate.
    #1;
    check_eq("b2b_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      in_func = F_ADD; in_a = 48'(i * 100); in_b = 48'(i); in_tag = 4'(i); in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_tag",   out_tag, 4'(i));
      check_eq("b2b_res",   out_res, 48'(i * 101));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_drained", out_valid, 0);

    // Reset in the middle of a MUL (or over a held result without the multiplier).
    out_ready = 1'b0;
    issue(F_MUL, 48'd3, 48'd4, 4'd2);
    idle(19);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_ready", in_ready, 1);
    check_eq("rst_mid_res",   out_res, 0);
    rises = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    check_eq("rst_mid_no_result", rises, 0);

    out_ready = 1'b1;
    run_op("illegal_12", 4'd12, 48'h1234, 48'h5678, 4'd15, 48'd0, 4'b0001, 1'b1);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
